// File: rtl/decompression_arbiter_pkg.sv
// Shared definitions for the compression/decompression arbiters: default sizes,
// header field offsets and the input framing state type.
package decompression_arbiter_pkg;
  localparam int COMP_CORES      = 4;
  localparam int AXI_DATA_BITS   = 512;
  localparam int PAGE_SIZE       = 4096;
  localparam int PAGE_SIZE_WIDTH = 16;

  localparam int HDR_COM_LSB   = 0;
  localparam int HDR_UNCOM_LSB = PAGE_SIZE_WIDTH;

  typedef enum logic {HDR = 1'b0, BODY = 1'b1} dstate_t;
endpackage

// File: rtl/decompression_arbiter_fifo.sv
// Small synchronous show-ahead FIFO; here it queues the expected uncompressed
// page sizes between header acceptance and page completion.
module decompression_arbiter_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_rdata = r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == LAST) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == LAST) ? '0 : r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
  end
endmodule

// File: rtl/decompression_arbiter.sv
// Strips page headers, deals compressed bodies round-robin to the cores and
// merges their output back in arrival order. Define DECOMP_STATS_EN for counters.
module decompression_arbiter #(
  parameter int COMP_CORES  = decompression_arbiter_pkg::COMP_CORES,
  parameter int DATA_BITS   = decompression_arbiter_pkg::AXI_DATA_BITS,
  parameter int SIZE_W      = decompression_arbiter_pkg::PAGE_SIZE_WIDTH,
  parameter int SFIFO_DEPTH = 2 * COMP_CORES
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [DATA_BITS-1:0]              s_tdata,
  input  logic [DATA_BITS/8-1:0]            s_tkeep,
  input  logic                              s_tlast,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  output logic [COMP_CORES*DATA_BITS-1:0]   core_in_tdata,
  output logic [COMP_CORES*DATA_BITS/8-1:0] core_in_tkeep,
  output logic [COMP_CORES-1:0]             core_in_tlast,
  output logic [COMP_CORES-1:0]             core_in_tvalid,
  input  logic [COMP_CORES-1:0]             core_in_tready,
  input  logic [COMP_CORES*DATA_BITS-1:0]   core_out_tdata,
  input  logic [COMP_CORES*DATA_BITS/8-1:0] core_out_tkeep,
  input  logic [COMP_CORES-1:0]             core_out_tlast,
  input  logic [COMP_CORES-1:0]             core_out_tvalid,
  output logic [COMP_CORES-1:0]             core_out_tready,
  output logic [DATA_BITS-1:0]              m_tdata,
  output logic [DATA_BITS/8-1:0]            m_tkeep,
  output logic                              m_tlast,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              err_com_size,
  output logic                              err_uncom_size,
  output logic [31:0]                       stat_pages_in,
  output logic [31:0]                       stat_pages_out,
  output logic [31:0]                       stat_errors
);
  import decompression_arbiter_pkg::*;

  localparam int KEEP_W    = DATA_BITS / 8;
  localparam int CNT_W     = $clog2(KEEP_W + 1);
  localparam int PTR_W     = (COMP_CORES > 1) ? $clog2(COMP_CORES) : 1;
  localparam int UNCOM_LSB = HDR_COM_LSB + SIZE_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(COMP_CORES - 1);

  function automatic logic [CNT_W-1:0] keep_bytes(input logic [KEEP_W-1:0] k);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int b = 0; b < KEEP_W; b++) n = n + CNT_W'(k[b]);
    return n;
  endfunction

  // Byte counters stick at all-ones instead of wrapping, so an oversized body still mismatches.
  function automatic logic [SIZE_W:0] sat_add(input logic [SIZE_W:0] a, input logic [CNT_W-1:0] b);
    logic [SIZE_W+1:0] s;
    s = {1'b0, a} + (SIZE_W + 2)'(b);
    return s[SIZE_W+1] ? '1 : s[SIZE_W:0];
  endfunction

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  dstate_t          r_state;
  dstate_t          w_state_nxt;
  logic [PTR_W-1:0] r_in_ptr;
  logic [PTR_W-1:0] r_out_ptr;
  logic [SIZE_W-1:0] r_exp_com;
  logic [SIZE_W:0]  r_in_bytes;
  logic [SIZE_W:0]  r_out_bytes;
  logic [SIZE_W:0]  w_in_sum;
  logic [SIZE_W:0]  w_out_sum;
  logic             r_err_com;
  logic             r_err_uncom;
  logic             w_s_hs;
  logic             w_hdr_hs;
  logic             w_in_last_hs;
  logic             w_m_hs;
  logic             w_m_last_hs;
  logic             w_sf_full;
  logic             w_sf_empty;
  logic [SIZE_W-1:0] w_sf_head;

  assign w_s_hs       = s_tvalid && s_tready;
  assign w_hdr_hs     = w_s_hs && (r_state == HDR);
  assign w_in_last_hs = w_s_hs && (r_state == BODY) && s_tlast;
  assign w_in_sum     = sat_add(r_in_bytes, keep_bytes(s_tkeep));

  always_ff @(posedge aclk) begin
    if (areset) r_state <= HDR;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HDR:     if (w_s_hs) w_state_nxt = BODY;
      BODY:    if (w_s_hs && s_tlast) w_state_nxt = HDR;
      default: w_state_nxt = HDR;
    endcase
  end

  always_comb begin
    s_tready       = 1'b0;
    core_in_tvalid = '0;
    case (r_state)
      HDR: s_tready = !w_sf_full;
      BODY: begin
        s_tready                 = core_in_tready[r_in_ptr];
        core_in_tvalid[r_in_ptr] = s_tvalid;
      end
      default: s_tready = 1'b0;
    endcase
  end

  // Payload fans out to every core; only the selected core sees tvalid.
  assign core_in_tdata = {COMP_CORES{s_tdata}};
  assign core_in_tkeep = {COMP_CORES{s_tkeep}};
  assign core_in_tlast = {COMP_CORES{s_tlast}};

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_in_ptr   <= '0;
      r_in_bytes <= '0;
      r_err_com  <= 1'b0;
    end else begin
      r_err_com <= 1'b0;
      if (w_hdr_hs) r_in_bytes <= '0;
      else if (w_s_hs) r_in_bytes <= w_in_sum;
      if (w_in_last_hs) begin
        r_err_com <= (w_in_sum != {1'b0, r_exp_com});
        r_in_ptr  <= wrap_inc(r_in_ptr);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hdr_hs) r_exp_com <= s_tdata[HDR_COM_LSB +: SIZE_W];
  end

  // Output merge: only the core owning the oldest outstanding page may drain.
  assign m_tdata     = core_out_tdata[int'(r_out_ptr) * DATA_BITS +: DATA_BITS];
  assign m_tkeep     = core_out_tkeep[int'(r_out_ptr) * KEEP_W +: KEEP_W];
  assign m_tlast     = core_out_tlast[r_out_ptr];
  assign m_tvalid    = core_out_tvalid[r_out_ptr] && !w_sf_empty;
  assign w_m_hs      = m_tvalid && m_tready;
  assign w_m_last_hs = w_m_hs && m_tlast;
  assign w_out_sum   = sat_add(r_out_bytes, keep_bytes(m_tkeep));

  always_comb begin
    core_out_tready            = '0;
    core_out_tready[r_out_ptr] = m_tready && !w_sf_empty;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_out_ptr   <= '0;
      r_out_bytes <= '0;
      r_err_uncom <= 1'b0;
    end else begin
      r_err_uncom <= 1'b0;
      if (w_m_last_hs) begin
        r_err_uncom <= (w_out_sum != {1'b0, w_sf_head});
        r_out_bytes <= '0;
        r_out_ptr   <= wrap_inc(r_out_ptr);
      end else if (w_m_hs) begin
        r_out_bytes <= w_out_sum;
      end
    end
  end

  decompression_arbiter_fifo #(
    .WIDTH (SIZE_W),
    .DEPTH (SFIFO_DEPTH)
  ) u_size_q (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_push  (w_hdr_hs),
    .i_wdata (s_tdata[UNCOM_LSB +: SIZE_W]),
    .i_pop   (w_m_last_hs),
    .o_rdata (w_sf_head),
    .o_full  (w_sf_full),
    .o_empty (w_sf_empty)
  );

  assign err_com_size   = r_err_com;
  assign err_uncom_size = r_err_uncom;

`ifdef DECOMP_STATS_EN
  logic [31:0] r_pages_in;
  logic [31:0] r_pages_out;
  logic [31:0] r_errors;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pages_in  <= '0;
      r_pages_out <= '0;
      r_errors    <= '0;
    end else begin
      if (w_in_last_hs) r_pages_in  <= r_pages_in + 32'd1;
      if (w_m_last_hs)  r_pages_out <= r_pages_out + 32'd1;
      r_errors <= r_errors + 32'(r_err_com) + 32'(r_err_uncom);
    end
  end

  assign stat_pages_in  = r_pages_in;
  assign stat_pages_out = r_pages_out;
  assign stat_errors    = r_errors;
`else
  assign stat_pages_in  = '0;
  assign stat_pages_out = '0;
  assign stat_errors    = '0;
`endif
endmodule

// File: tb/tb_decompression_arbiter.sv
// Bench for decompression_arbiter: the bench plays host and cores, and a
// frame-level model predicts routing, output order and size-error pulses.
module tb_decompression_arbiter;
  localparam int NC = 4;
  localparam int DB = 512;
  localparam int KW = DB / 8;
  localparam int SW = 16;

  typedef struct {logic [DB-1:0] d; logic [KW-1:0] k; logic l;} beat_t;
  typedef struct {int core; logic [DB-1:0] d; logic [KW-1:0] k; logic l;} ibeat_t;
  typedef struct {bit com_bad; bit uncom_bad;} rec_t;

  logic aclk = 1'b0;
  logic areset;
  logic [DB-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic s_tlast, s_tvalid, s_tready;
  logic [NC*DB-1:0] core_in_tdata, core_out_tdata;
  logic [NC*KW-1:0] core_in_tkeep, core_out_tkeep;
  logic [NC-1:0] core_in_tlast, core_in_tvalid, core_in_tready;
  logic [NC-1:0] core_out_tlast, core_out_tvalid, core_out_tready;
  logic [DB-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic m_tlast, m_tvalid, m_tready;
  logic err_com_size, err_uncom_size;
  logic [31:0] stat_pages_in, stat_pages_out, stat_errors;

  always #5 aclk = ~aclk;

  decompression_arbiter dut (
    .aclk(aclk), .areset(areset),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .core_in_tdata(core_in_tdata), .core_in_tkeep(core_in_tkeep), .core_in_tlast(core_in_tlast),
    .core_in_tvalid(core_in_tvalid), .core_in_tready(core_in_tready),
    .core_out_tdata(core_out_tdata), .core_out_tkeep(core_out_tkeep), .core_out_tlast(core_out_tlast),
    .core_out_tvalid(core_out_tvalid), .core_out_tready(core_out_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .err_com_size(err_com_size), .err_uncom_size(err_uncom_size),
    .stat_pages_in(stat_pages_in), .stat_pages_out(stat_pages_out), .stat_errors(stat_errors)
  );

  int n_cmp = 0;
  int n_fail = 0;
  beat_t  cq [NC][$];
  bit     core_en [NC];
  bit     pop_pend [NC];
  ibeat_t exp_in [$];
  beat_t  exp_out [$];
  rec_t   in_recs [$];
  rec_t   out_recs [$];
  int model_core = 0;
  int fid = 0;
  bit rnd_bp = 0;
  bit tb_hdr = 0;
  bit exp_com_p = 0;
  bit exp_unc_p = 0;
  int n_err_com = 0;
  int n_err_unc = 0;
  int n_m_beats = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_w(string name, logic [DB-1:0] act, logic [DB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [KW-1:0] keep_of(int n);
    logic [KW-1:0] k;
    k = '0;
    for (int b = 0; b < n && b < KW; b++) k[b] = 1'b1;
    return k;
  endfunction

  function automatic logic [DB-1:0] pat(int id, int beat, bit page);
    logic [31:0] w;
    w = {page, 15'(id), 16'(beat)};
    return {16{w}};
  endfunction

  // Cores: each replays its queued pages when enabled.
  always @(posedge aclk) begin
    #1;
    for (int i = 0; i < NC; i++) begin
      if (pop_pend[i] && cq[i].size() > 0) void'(cq[i].pop_front());
      pop_pend[i] = 1'b0;
      if (core_en[i] && cq[i].size() > 0) begin
        core_out_tvalid[i]           = 1'b1;
        core_out_tdata[i*DB +: DB]   = cq[i][0].d;
        core_out_tkeep[i*KW +: KW]   = cq[i][0].k;
        core_out_tlast[i]            = cq[i][0].l;
      end else begin
        core_out_tvalid[i] = 1'b0;
        core_out_tlast[i]  = 1'b0;
      end
    end
    core_in_tready = rnd_bp ? 4'($urandom) : '1;
    m_tready       = rnd_bp ? 1'($urandom) : 1'b1;
  end

  // Per-cycle comparison against the frame-level model.
  always @(negedge aclk) begin
    ibeat_t ei;
    beat_t  eo;
    rec_t   r;
    if (areset) begin
      exp_com_p = 0;
      exp_unc_p = 0;
      for (int i = 0; i < NC; i++) pop_pend[i] = 1'b0;
    end else begin
      check("err_com_size", 64'(err_com_size), 64'(exp_com_p));
      check("err_uncom_size", 64'(err_uncom_size), 64'(exp_unc_p));
      n_err_com += int'(err_com_size);
      n_err_unc += int'(err_uncom_size);
      exp_com_p = 0;
      exp_unc_p = 0;
      check("core_in_onehot", 64'($countones(core_in_tvalid) <= 1), 64'd1);
      if (tb_hdr) check("core_in_tvalid_in_hdr", 64'(core_in_tvalid), 64'd0);
      for (int i = 0; i < NC; i++) begin
        if (core_in_tvalid[i] && core_in_tready[i]) begin
          if (exp_in.size() == 0) begin
            check("core_in_unexpected_beat", 64'(i), 64'hFFFF);
          end else begin
            ei = exp_in.pop_front();
            check("core_in_route", 64'(i), 64'(ei.core));
            check_w("core_in_tdata", core_in_tdata[i*DB +: DB], ei.d);
            check("core_in_tkeep", core_in_tkeep[i*KW +: KW], ei.k);
            check("core_in_tlast", 64'(core_in_tlast[i]), 64'(ei.l));
            if (ei.l && in_recs.size() > 0) begin
              r = in_recs.pop_front();
              exp_com_p = r.com_bad;
            end
          end
        end
        pop_pend[i] = core_out_tvalid[i] && core_out_tready[i];
      end
      if (m_tvalid && m_tready) begin
        n_m_beats++;
        if (exp_out.size() == 0) begin
          check("m_unexpected_beat", 64'd1, 64'd0);
        end else begin
          eo = exp_out.pop_front();
          check_w("m_tdata", m_tdata, eo.d);
          check("m_tkeep", m_tkeep, eo.k);
          check("m_tlast", 64'(m_tlast), 64'(eo.l));
          if (eo.l && out_recs.size() > 0) begin
            r = out_recs.pop_front();
            exp_unc_p = r.uncom_bad;
          end
        end
      end
    end
  end

  task automatic drive(logic [DB-1:0] d, logic [KW-1:0] k, logic l);
    int t = 0;
    bit done = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    while (!done) begin
      @(negedge aclk);
      if (s_tready) done = 1;
      else if (++t > 3000) begin
        n_cmp++; n_fail++;
        $display("FAIL s_handshake_timeout: got no s_tready within %0d cycles, required a handshake", t);
        done = 1;
      end
    end
    @(posedge aclk); #1;
  endtask

  task automatic send_frame(int com, int uncom, int body_b, int page_b, bit abort);
    int core, id, nb;
    rec_t r;
    beat_t p;
    ibeat_t e;
    logic [DB-1:0] h;
    ibeat_t body [$];
    core = model_core;
    id = fid++;
    model_core = (model_core + 1) % NC;
    r.com_bad = (body_b != com);
    r.uncom_bad = (page_b != uncom);
    if (!abort) begin
      nb = (page_b + KW - 1) / KW;
      for (int b = 0; b < nb; b++) begin
        p.d = pat(id, b, 1);
        p.k = keep_of((b == nb - 1) ? page_b - b * KW : KW);
        p.l = (b == nb - 1);
        cq[core].push_back(p);
        exp_out.push_back(p);
      end
      out_recs.push_back(r);
    end
    in_recs.push_back(r);
    nb = (body_b + KW - 1) / KW;
    for (int b = 0; b < nb; b++) begin
      e.core = core;
      e.d = pat(id, b, 0);
      e.k = keep_of((b == nb - 1) ? body_b - b * KW : KW);
      e.l = (b == nb - 1);
      if (!(abort && b > 0)) begin
        body.push_back(e);
        exp_in.push_back(e);
      end
    end
    h = pat(id, 16'hABCD, 1);
    h[SW-1:0] = SW'(com);
    h[2*SW-1:SW] = SW'(uncom);
    tb_hdr = 1;
    drive(h, KW'({$urandom, $urandom}), 1'b0);
    tb_hdr = 0;
    foreach (body[b]) drive(body[b].d, body[b].k, body[b].l);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_out.size() != 0 || exp_in.size() != 0) && t < 5000) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 5000) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d output beats still outstanding, required 0", exp_out.size());
    end
    repeat (3) @(negedge aclk);
    @(posedge aclk); #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s_tvalid = 1'b0;
    @(negedge aclk);
    for (int i = 0; i < NC; i++) cq[i].delete();
    exp_in.delete(); exp_out.delete(); in_recs.delete(); out_recs.delete();
    model_core = 0;
    @(posedge aclk); @(posedge aclk); #1;
    areset = 1'b0;
  endtask

  task automatic set_all_en(bit v);
    for (int i = 0; i < NC; i++) core_en[i] = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
    core_in_tready = '1; m_tready = 1'b1;
    core_out_tvalid = '0; core_out_tlast = '0; core_out_tdata = '0; core_out_tkeep = '0;
    set_all_en(1);
    @(posedge aclk); #1;
    do_reset();
    @(negedge aclk);
    check("rst_s_tready", 64'(s_tready), 64'd1);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_err_com", 64'(err_com_size), 64'd0);
    check("rst_err_uncom", 64'(err_uncom_size), 64'd0);
    check("rst_stat_pages_in", 64'(stat_pages_in), 64'd0);
    check("rst_stat_pages_out", 64'(stat_pages_out), 64'd0);
    check("rst_stat_errors", 64'(stat_errors), 64'd0);
    @(posedge aclk); #1;

    // Single frame: 64+36 body bytes, 4 full output beats from core 0.
    n_m_beats = 0; n_err_com = 0; n_err_unc = 0;
    send_frame(100, 256, 100, 256, 0);
    wait_drain();
    check("single_m_beats", 64'(n_m_beats), 64'd4);
    check("single_err_pulses", 64'(n_err_com + n_err_unc), 64'd0);
    send_frame(64, 64, 64, 64, 0);
    wait_drain();

    // Round robin: core 2 ready first, core 0 last.
    do_reset();
    set_all_en(0);
    for (int f = 0; f < 5; f++) send_frame(128, 192, 128, 192, 0);
    core_en[2] = 1;
    repeat (6) @(negedge aclk);
    check("rr_core2_valid", 64'(core_out_tvalid[2]), 64'd1);
    check("rr_core2_held", 64'(core_out_tready[2]), 64'd0);
    check("rr_m_idle", 64'(m_tvalid), 64'd0);
    @(posedge aclk); #1;
    core_en[3] = 1;
    repeat (4) @(posedge aclk); #1;
    core_en[1] = 1;
    repeat (4) @(posedge aclk); #1;
    core_en[0] = 1;
    wait_drain();

    // Size mismatch on both sides.
    n_m_beats = 0; n_err_com = 0; n_err_unc = 0;
    send_frame(100, 256, 99, 250, 0);
    wait_drain();
    check("mm_err_com_pulses", 64'(n_err_com), 64'd1);
    check("mm_err_uncom_pulses", 64'(n_err_unc), 64'd1);
    check("mm_m_beats", 64'(n_m_beats), 64'd4);

    // Size queue full with all core outputs stalled.
    do_reset();
    set_all_en(0);
    for (int f = 0; f < 8; f++) send_frame(64, 64, 64, 64, 0);
    fork
      send_frame(64, 64, 64, 64, 0);
      begin
        repeat (5) @(negedge aclk);
        check("full_s_tready", 64'(s_tready), 64'd0);
        check("full_m_idle", 64'(m_tvalid), 64'd0);
        @(posedge aclk); #1;
        core_en[0] = 1;
      end
    join
    set_all_en(1);
    wait_drain();

    // Random backpressure, then reset in the middle of a body.
    rnd_bp = 1;
    send_frame(200, 300, 200, 300, 0);
    send_frame(1, 1, 1, 1, 0);
    send_frame(130, 129, 130, 129, 0);
    send_frame(64, 512, 64, 512, 0);
    send_frame(300, 70, 300, 70, 0);
    wait_drain();
    rnd_bp = 0;
    repeat (2) @(posedge aclk); #1;
    send_frame(128, 128, 128, 128, 1);
    do_reset();
    @(negedge aclk);
    check("post_rst_s_tready", 64'(s_tready), 64'd1);
    check("post_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge aclk); #1;

    // Statistics: three clean frames and one with both mismatches.
    for (int f = 0; f < 3; f++) send_frame(100, 200, 100, 200, 0);
    send_frame(100, 256, 99, 250, 0);
    wait_drain();
`ifdef DECOMP_STATS_EN
    check("stat_pages_in", 64'(stat_pages_in), 64'd4);
    check("stat_pages_out", 64'(stat_pages_out), 64'd4);
    check("stat_errors", 64'(stat_errors), 64'd2);
`else
    check("stat_pages_in_tied", 64'(stat_pages_in), 64'd0);
    check("stat_pages_out_tied", 64'(stat_pages_out), 64'd0);
    check("stat_errors_tied", 64'(stat_errors), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/decompression_arbiter.md
Name: decompression_arbiter

Overview:
- Inverse of the compression path: accepts the framed stream from the host, one page per frame.
- Frame layout: a header beat followed by compressed body beats.
- Strips each header and dispatches the body round-robin to COMP_CORES external decompression cores.
- Collects core outputs in the same round-robin order, so decompressed pages leave in arrival order, and checks both compressed and uncompressed byte counts against the header.

Parameters:
- COMP_CORES, 4, number of decompression cores; power of two not required.
- DATA_BITS, 512, AXI stream data width (= AXI_DATA_BITS).
- SIZE_W, 16, width of each header size field; must hold PAGE_SIZE.
- SFIFO_DEPTH, 2*COMP_CORES, depth of expected-uncompressed-size queue.

Ports:
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- s_tdata  in  DATA_BITS  framed stream from host
- s_tkeep  in  DATA_BITS/8  byte enables
- s_tlast  in  1  last body beat of a frame
- s_tvalid  in  1  source valid
- s_tready  out  1  sink ready
- core_in_tdata  out  COMP_CORES*DATA_BITS  compressed body to core i (slice i)
- core_in_tkeep  out  COMP_CORES*DATA_BITS/8  byte enables per core
- core_in_tlast  out  COMP_CORES  last per core
- core_in_tvalid  out  COMP_CORES  valid per core
- core_in_tready  in  COMP_CORES  ready per core
- core_out_tdata  in  COMP_CORES*DATA_BITS  decompressed data from core i
- core_out_tkeep  in  COMP_CORES*DATA_BITS/8  byte enables per core
- core_out_tlast  in  COMP_CORES  last per core
- core_out_tvalid  in  COMP_CORES  valid per core
- core_out_tready  out  COMP_CORES  ready per core
- m_tdata  out  DATA_BITS  decompressed stream to host
- m_tkeep  out  DATA_BITS/8  byte enables
- m_tlast  out  1  end of page
- m_tvalid  out  1  valid
- m_tready  in  1  ready
- err_com_size  out  1  one-cycle pulse: body byte count != header com_size
- err_uncom_size  out  1  one-cycle pulse: output byte count != header uncom_size
- stat_pages_in  out  32  statistics, see Optional Feature
- stat_pages_out  out  32  statistics, see Optional Feature
- stat_errors  out  32  statistics, see Optional Feature

Behaviour:
- Clock and reset: single clock aclk; areset is synchronous, active-high.
- Reset:
  - Input FSM returns to HDR; in_ptr and out_ptr return to 0; byte counters return to 0; size queue is emptied.
  - err_* and stat_* outputs are 0.
  - Reset mid-frame drops the partial frame; the cores are reset by the same areset.
- Header format (one full beat):
  - com_size = s_tdata[SIZE_W-1:0]; uncom_size = s_tdata[2*SIZE_W-1:SIZE_W].
  - s_tkeep is ignored on the header beat. s_tlast on a header beat is illegal and is ignored.
- Input FSM {HDR, BODY}:
  - HDR:
    - s_tready = !sfifo_full.
    - On handshake: latch com_size into exp_com; push uncom_size into the size queue; clear in_bytes; go to BODY.
    - No core_in_tvalid is driven in HDR.
  - BODY:
    - core_in_*[in_ptr] = s_* combinationally; core_in_tvalid[j!=in_ptr] = 0.
    - s_tready = core_in_tready[in_ptr]. Zero latency, no registering.
    - Each handshake adds $countones(s_tkeep) to in_bytes (SIZE_W+1 bits, no wrap).
    - On the tlast handshake: if in_bytes + beat bytes != exp_com, pulse err_com_size the next cycle; in_ptr <= (in_ptr == COMP_CORES-1) ? 0 : in_ptr+1; go to HDR.
- Output path:
  - m_* = core_out_*[out_ptr].
  - m_tvalid = core_out_tvalid[out_ptr] && !sfifo_empty.
  - core_out_tready[out_ptr] = m_tready && !sfifo_empty; all other cores get tready = 0.
  - out_bytes accumulates $countones(m_tkeep) per handshake.
  - On the m_tlast handshake:
    - compare with the queue head; pulse err_uncom_size next cycle on mismatch;
    - pop the queue; clear out_bytes; advance out_ptr with the same wrap rule.
- Ordering: a core may finish early, but its output is held (tready low) until out_ptr reaches it.
- Simultaneous events:
  - A queue push (header accepted) and pop (output tlast) in the same cycle are both performed; the level is unchanged.
  - A pop when the queue is full frees a slot visible to s_tready on the next cycle.
- Error handling: errors never stall or drop data; the frame/page is still forwarded through tlast.
- Outputs carry no tid; host-side tid, if present, is driven 0.

Optional Feature:
- Macro: DECOMP_STATS_EN.
- With the macro defined:
  - stat_pages_in increments on each input tlast handshake.
  - stat_pages_out increments on each m_tlast handshake.
  - stat_errors increments on each err_com_size or err_uncom_size pulse; +2 if both pulse in the same cycle.
  - All three are 32-bit wrapping counters, cleared by areset.
- Without the macro: the three ports are tied to 0 and no counter logic is synthesized.

Decomposition:
- Shared package (common): COMP_CORES, AXI_DATA_BITS, PAGE_SIZE, PAGE_SIZE_WIDTH.
- Also in common: header field offsets HDR_COM_LSB = 0 and HDR_UNCOM_LSB = SIZE_W, shared with the compression arbiter.
- Also in common: enum type dstate_t {HDR, BODY}.
- Sub-module: the size queue is the existing FIFO module, WIDTH = SIZE_W, DEPTH = SFIFO_DEPTH. No other sub-module.

Test Plan:
- Single frame:
  - Stimulus: header com=100, uncom=256; body 2 beats (64 + 36 bytes, tlast on beat 2). Core 0 returns 4 full beats with tlast.
  - Response: m_ emits 4 beats, tlast on beat 4; no error pulse; in_ptr = out_ptr = 1.
- Round-robin ordering:
  - Stimulus: 5 frames with COMP_CORES=4; core 2 finishes first, core 0 last.
  - Response: m_ pages appear in order core 0,1,2,3,0; core 2 is held with tready=0 until page 1 ends.
- Size mismatch:
  - Stimulus: header com=100, body carries 99 bytes; core returns 250 bytes against uncom=256.
  - Response: err_com_size and err_uncom_size each pulse for exactly 1 cycle; data is still fully forwarded.
- Queue full:
  - Stimulus: 8 headers accepted while all core outputs are stalled.
  - Response: s_tready = 0 in HDR on the 9th header until one m_tlast pop occurs; the pop and a new push in the same cycle keep the level at 8.
- Backpressure and reset:
  - Stimulus: random m_tready and core_in_tready; then areset asserted mid-BODY.
  - Response: no beat lost or duplicated before reset. The cycle after reset: s_tready = 1 (HDR, queue empty), m_tvalid = 0, in_ptr = 0.
- DECOMP_STATS_EN defined:
  - Stimulus: 3 clean frames plus 1 frame with both mismatches.
  - Response: stat_pages_in = 4, stat_pages_out = 4, stat_errors = 2.
